// File: rtl/uart_prog_loader.sv
// Boot loader: receives a word-count header and little-endian 32-bit words over
// 8N1 UART and writes them to program memory, holding the CPU in reset meanwhile.
module uart_prog_loader #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 14,
  parameter int TIMEOUT  = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int BW      = $clog2(BIT_CYC + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int CW      = ADDR_W + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, WORD, DONE, ERR} state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_prev;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_valid, frame_err;
  logic          tick_half, tick_full;

  state_t        state, state_next;
  logic [15:0]   n_words;
  logic [15:0]   hdr_word;
  logic [CW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          in_load;

  always_comb begin
    rx_next   = rx_state;
    tick_half = (bit_cnt == BW'(HALF - 1));
    tick_full = (bit_cnt == BW'(BIT_CYC - 1));
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (tick_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer restarts at the half-bit start check and at every full-bit sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || (rx_state == RX_START && tick_half) || tick_full)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
      if (rx_state == RX_DATA && tick_full) begin
        rx_byte <= {rx_s2, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (rx_state == RX_STOP && tick_full) begin
        byte_valid <= rx_s2;
        frame_err  <= !rx_s2;
      end
    end
  end

  assign in_load  = (state == HDR0) || (state == HDR1) || (state == WORD);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT)) && !byte_valid;
  assign hdr_word = {rx_byte, n_words[7:0]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = HDR0;
      HDR0: begin
        if (frame_err || tmo_hit)  state_next = ERR;
        else if (byte_valid)       state_next = HDR1;
      end
      HDR1: begin
        if (frame_err || tmo_hit) state_next = ERR;
        else if (byte_valid) begin
          if (hdr_word == 16'd0)                   state_next = DONE;
          else if ({16'd0, hdr_word} > CAPACITY)   state_next = ERR;
          else                                     state_next = WORD;
        end
      end
      WORD: begin
        // word_idx has already advanced when the final mem_we is on the bus
        if (mem_we && word_idx == CW'(n_words)) state_next = DONE;
        else if (frame_err || tmo_hit)          state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      tmo_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      mem_we    <= 1'b0;
      cpu_rst_n <= (state_next == IDLE) || (state_next == DONE);
      busy      <= (state_next == HDR0) || (state_next == HDR1) || (state_next == WORD);
      done      <= (state_next == DONE);
      err       <= (state_next == ERR);
      if (!in_load && state_next == HDR0) begin
        word_idx <= '0;
        byte_idx <= '0;
        tmo_cnt  <= '0;
      end else if (in_load) begin
        if (byte_valid)
          tmo_cnt <= '0;
        else if (tmo_cnt != TW'(TIMEOUT))
          tmo_cnt <= tmo_cnt + 1'b1;
        if (byte_valid) begin
          case (state)
            HDR0: n_words[7:0]  <= rx_byte;
            HDR1: n_words[15:8] <= rx_byte;
            WORD: begin
              word_buf <= {rx_byte, word_buf[31:8]};
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx == 2'd3) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_idx[ADDR_W-1:0];
                mem_wdata <= {rx_byte, word_buf[31:8]};
                word_idx  <= word_idx + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: builds frames from random words, drives them over rx
// and compares memory writes and status against a word-level model of the protocol.
module tb_uart_prog_loader;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int ADDR_W   = 4;
  localparam int TIMEOUT  = 400;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int CAP      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, rx, start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n, busy, done, err;

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;
  int last_we_cyc   = -1;
  int done_rise_cyc = -1;
  int last_fall_cyc = 0;
  logic done_prev = 1'b0;

  logic [31:0] obs_addr[$], obs_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] words_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] dut_mem[CAP];
  logic [31:0] model_mem[CAP];

  uart_prog_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor: records every write as the program memory would see it.
  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr.push_back(32'(mem_addr));
      obs_data.push_back(mem_wdata);
      dut_mem[mem_addr] = mem_wdata;
      last_we_cyc = cyc;
    end
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_fall_cyc = cyc;
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  // Frame model: header N, then N words LSB-first; a legal N yields writes 0..N-1.
  task automatic build_frame(input int n);
    logic [31:0] w;
    logic [15:0] hdr;
    hdr = 16'(n);
    byte_q.delete();
    exp_addr.delete();
    exp_data.delete();
    byte_q.push_back(hdr[7:0]);
    byte_q.push_back(hdr[15:8]);
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        w = words_q[i];
        for (int b = 0; b < 4; b++) byte_q.push_back(w[8*b +: 8]);
        exp_addr.push_back(32'(i));
        exp_data.push_back(w);
        model_mem[i] = w;
      end
    end
  endtask

  task automatic send_bytes(input int count, input int start_at);
    for (int i = 0; i < count; i++) begin
      send_byte(byte_q[i], 1'b1);
      if (i == start_at) pulse_start();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check_output({tag, "_wcount"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_output($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      check_output($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic apply_stimulus(input string tag, input int n, input int start_at);
    bit ok;
    ok = (n <= CAP);
    pulse_start();
    check_output({tag, "_busy_on"}, 32'(busy), 32'd1);
    check_output({tag, "_cpurst_on"}, 32'(cpu_rst_n), 32'd0);
    build_frame(n);
    send_bytes(byte_q.size(), start_at);
    wait_idle(tag, 50);
    check_output({tag, "_done"}, 32'(done), 32'(ok));
    check_output({tag, "_err"}, 32'(err), 32'(!ok));
    check_output({tag, "_cpurst"}, 32'(cpu_rst_n), 32'(ok));
    check_writes(tag);
    if (ok && n > 0) check_output({tag, "_done_lat"}, 32'(done_rise_cyc), 32'(last_we_cyc + 1));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int delta;
    for (int i = 0; i < CAP; i++) begin
      dut_mem[i]   = 32'd0;
      model_mem[i] = 32'd0;
    end
    rst = 1'b0;
    rx = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_we", 32'(mem_we), 32'd0);
    check_output("rst_addr", 32'(mem_addr), 32'd0);
    check_output("rst_wdata", mem_wdata, 32'd0);
    check_output("rst_cpurst", 32'(cpu_rst_n), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    words_q.delete();
    words_q.push_back(32'h0010_0513);
    words_q.push_back(32'h00A5_05B3);
    apply_stimulus("prog2", 2, -1);
    check_output("prog2_busy", 32'(busy), 32'd0);

    apply_stimulus("empty", 0, -1);

    apply_stimulus("too_big", CAP + 1, -1);
    check_output("too_big_busy", 32'(busy), 32'd0);

    rand_words(CAP);
    apply_stimulus("full", CAP, -1);

    for (int t = 0; t < 3; t++) begin
      rand_words($urandom_range(1, 8));
      apply_stimulus($sformatf("rand%0d", t), words_q.size(), -1);
    end

    rand_words(2);
    apply_stimulus("start_ign", 2, 5);

    // A short low pulse must not be taken as a byte: a following 00 00 header completes.
    pulse_start();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_output("glitch_busy", 32'(busy), 32'd1);
    build_frame(0);
    send_bytes(2, -1);
    wait_idle("glitch", 50);
    check_output("glitch_done", 32'(done), 32'd1);
    check_output("glitch_err", 32'(err), 32'd0);

    pulse_start();
    send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    check_output("frame_err", 32'(err), 32'd1);
    check_output("frame_busy", 32'(busy), 32'd0);
    check_output("frame_cpurst", 32'(cpu_rst_n), 32'd0);

    rand_words(1);
    pulse_start();
    build_frame(1);
    exp_addr.delete();
    exp_data.delete();
    send_bytes(4, -1);
    for (int i = 0; i < 700 && !err; i++) @(negedge clk);
    delta = cyc - last_fall_cyc;
    check_output("tmo_err", 32'(err), 32'd1);
    check_output("tmo_window", 32'(delta >= 9 * BIT_CYC + BIT_CYC / 2 + TIMEOUT &&
                                   delta <= 9 * BIT_CYC + BIT_CYC / 2 + TIMEOUT + 8), 32'd1);
    check_output("tmo_cpurst", 32'(cpu_rst_n), 32'd0);
    check_writes("tmo");

    // Reset in the middle of the third word: outputs drop asynchronously, memory keeps words 0-1.
    rand_words(3);
    pulse_start();
    build_frame(3);
    void'(exp_addr.pop_back());
    void'(exp_data.pop_back());
    send_bytes(11, -1);
    check_output("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_we", 32'(mem_we), 32'd0);
    check_output("arst_addr", 32'(mem_addr), 32'd0);
    check_output("arst_wdata", mem_wdata, 32'd0);
    check_output("arst_cpurst", 32'(cpu_rst_n), 32'd1);
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_done", 32'(done), 32'd0);
    check_output("arst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    check_writes("arst");
    check_output("arst_mem0", dut_mem[0], model_mem[0]);
    check_output("arst_mem1", dut_mem[1], model_mem[1]);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    rand_words($urandom_range(1, 4));
    apply_stimulus("after_rst", words_q.size(), -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Boot-time program loader placed upstream of instruction fetch: receives a program image over a UART RX line, assembles little-endian 32-bit words, and drives the write port of the program memory that instruction fetch reads. While loading, it holds the CPU core in reset so the PC restarts at 0 on release. On success it releases the core; on any protocol or line error it keeps the core in reset and flags the error.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115_200: UART bit rate; BIT_CYC = CLK_FREQ/BAUD (integer division, must be ≥ 4).
- ADDR_W, 14: program memory word-address width; capacity = 2^ADDR_W words.
- TIMEOUT, 100_000_000: maximum idle clock cycles between completed bytes while loading.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- rx  in  1  UART line, 8N1, idle high, asynchronous to clk.
- start  in  1  single-cycle pulse (already debounced) requesting a load.
- mem_we  out  1  program memory write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word to write.
- cpu_rst_n  out  1  active-low reset to the CPU core (combined externally with rst).
- busy  out  1  high while a load is in progress.
- done  out  1  high after a successful load, until the next start.
- err  out  1  high after a failed load, until the next start.

## Operation
- RX front end: rx passes through a 2-flop synchronizer (reset value 1). A falling edge in RX_IDLE starts a bit timer. At BIT_CYC/2 the line is resampled; if it is 1, the start is discarded (glitch) and RX_IDLE resumes. Otherwise 8 data bits are sampled LSB-first every BIT_CYC, then the stop bit. A stop bit of 1 yields a one-cycle byte_valid. A stop bit of 0 is a framing error.
- Frame format: 2-byte word count N (little-endian), followed by N words of 4 bytes each, least-significant byte first.
- Loader FSM states: IDLE, HDR0, HDR1, WORD, DONE, ERR.
  - IDLE/DONE/ERR + start → HDR0. This clears the word index, byte index, timeout counter, done and err.
  - start while in HDR0/HDR1/WORD is ignored.
  - HDR0: byte → N[7:0] → HDR1.
  - HDR1: byte → N[15:8].
    - N = 0 → DONE.
    - N > 2^ADDR_W → ERR.
    - otherwise → WORD.
  - WORD: bytes shift into a 32-bit assembler. On the 4th byte: mem_we = 1, mem_addr = word index, mem_wdata = assembled word. Then the word index increments and the byte index wraps to 0. After writing word N−1 → DONE.
  - Any of HDR0/HDR1/WORD + framing error → ERR.
  - Any of HDR0/HDR1/WORD + timeout counter reaching TIMEOUT → ERR. The counter restarts on entering HDR0 and on every byte_valid.
- Bytes arriving in IDLE/DONE/ERR are received and dropped.
- Outputs by state:
  - cpu_rst_n = 0 in HDR0/HDR1/WORD/ERR; 1 in IDLE/DONE.
  - busy = 1 exactly in HDR0/HDR1/WORD.
- Reset values: FSM IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst_n 1 (core runs the resident image), busy 0, done 0, err 0, RX in RX_IDLE.
- Reset asserted mid-load aborts immediately to the reset values. Words already written stay in memory.

## Timing
- byte_valid is asserted the cycle after the stop-bit sample, which is mid stop bit: about 9.5·BIT_CYC cycles after the start-bit falling edge.
- mem_we is asserted, registered, the cycle after the 4th byte_valid of a word. mem_addr/mem_wdata are valid in that same cycle only.
- The FSM enters DONE on the cycle following the last mem_we. cpu_rst_n rises and done sets in that cycle.
- Leaving ERR/DONE/IDLE on start: busy = 1 and cpu_rst_n = 0 on the next cycle.
- Timeout fires on the cycle the counter equals TIMEOUT. A byte_valid in that same cycle wins (counter restarts, no error).
- Back-to-back bytes (no idle gap after stop bit) must be received without loss.

## Test plan
- Params CLK_FREQ=16, BAUD=1 (BIT_CYC=16), ADDR_W=4, TIMEOUT=400. Reset, send start, send 02 00 13 05 10 00 B3 05 A5 00 → mem_we at addr 0 data 0x00100513, then addr 1 data 0x00A505B3. done=1, cpu_rst_n=1, busy=0 afterwards.
- Header 00 00 → DONE with no mem_we, cpu_rst_n held low only during the two header bytes.
- Header 11 00 (17 > 16 words) → ERR, err=1, cpu_rst_n=0, no mem_we. A following start plus a valid frame → done=1, err=0.
- Glitch: rx low for 5 cycles in HDR0 → no byte accepted. Then a byte with stop bit 0 → ERR on the stop sample.
- Header 01 00, then 2 bytes, then silence → ERR exactly 400 cycles after the 2nd byte_valid. A start pulse mid-load is ignored (addresses do not restart).
- Assert rst during WORD after 2 words → all outputs return to reset values asynchronously. Memory contents at addr 0–1 are unchanged.
